// File: rtl/io_bus_ctrl_if.sv
// CPU data-port and device-side signal bundle for io_bus_ctrl.
// slave is the controller's view; master is the CPU/device environment.
interface io_bus_ctrl_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DATA_W = 32
);
  logic [31:0]              addr;
  logic [DATA_W-1:0]        wdata;
  logic                     cs;
  logic                     sig_w;
  logic                     sig_r;
  logic [DATA_W-1:0]        rdata;
  logic                     stall;
  logic                     ack;
  logic                     err;
  logic [31:0]              err_addr;
  logic [NUM_CH-1:0]        dev_cs;
  logic                     dev_we;
  logic [DATA_W-1:0]        dev_wdata;
  logic [NUM_CH*DATA_W-1:0] dev_rdata;
  logic [NUM_CH-1:0]        dev_ready;

  modport slave (
    input  addr, wdata, cs, sig_w, sig_r, dev_rdata, dev_ready,
    output rdata, stall, ack, err, err_addr, dev_cs, dev_we, dev_wdata
  );

  modport master (
    output addr, wdata, cs, sig_w, sig_r, dev_rdata, dev_ready,
    input  rdata, stall, ack, err, err_addr, dev_cs, dev_we, dev_wdata
  );
endinterface

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O controller: decodes CPU accesses onto one-hot device
// selects, waits for device ready, and answers errors instead of hanging.
module io_bus_ctrl #(
  parameter int unsigned            NUM_CH  = 3,
  parameter int unsigned            DATA_W  = 32,
  parameter logic [32*NUM_CH-1:0]   CH_BASE = {32'h00000030, 32'h10010010, 32'h10010000},
  parameter logic [32*NUM_CH-1:0]   CH_MASK = {32'hFFFFFFFC, 32'hFFFFFFF0, 32'hFFFFFFF0},
  parameter int unsigned            TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  io_bus_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t           state;
  logic [31:0]      addr_q;
  logic [IDX_W-1:0] ch_idx;
  logic [CNT_W-1:0] cnt;
  logic             req;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  assign req       = bus.cs & (bus.sig_r | bus.sig_w);
  assign bus.stall = ((state == IDLE) & req) | (state == ACCESS);

  // Lowest-index matching channel wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!hit && ((bus.addr & CH_MASK[32*i +: 32]) ==
                   (CH_BASE[32*i +: 32] & CH_MASK[32*i +: 32]))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      ch_idx        <= '0;
      cnt           <= '0;
      bus.dev_cs    <= '0;
      bus.dev_we    <= 1'b0;
      bus.dev_wdata <= '0;
      bus.rdata     <= '0;
      bus.ack       <= 1'b0;
      bus.err       <= 1'b0;
      bus.err_addr  <= '0;
    end else begin
      bus.ack <= 1'b0;
      bus.err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q        <= bus.addr;
            ch_idx        <= hit_idx;
            bus.dev_we    <= bus.sig_w;
            bus.dev_wdata <= bus.wdata;
            if ((bus.sig_r && bus.sig_w) || !hit) begin
              state        <= ERR;
              bus.ack      <= 1'b1;
              bus.err      <= 1'b1;
              bus.rdata    <= '0;
              bus.err_addr <= bus.addr;
            end else begin
              state      <= ACCESS;
              cnt        <= '0;
              bus.dev_cs <= NUM_CH'(1) << hit_idx;
            end
          end
        end
        ACCESS: begin
          // Ready is checked first so it wins over a same-cycle timeout.
          if (bus.dev_ready[ch_idx]) begin
            state      <= DONE;
            bus.ack    <= 1'b1;
            bus.dev_cs <= '0;
            if (!bus.dev_we) bus.rdata <= bus.dev_rdata[DATA_W*ch_idx +: DATA_W];
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            state        <= ERR;
            bus.ack      <= 1'b1;
            bus.err      <= 1'b1;
            bus.rdata    <= '0;
            bus.err_addr <= addr_q;
            bus.dev_cs   <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Bench for io_bus_ctrl: cycle-offset transaction model checked every cycle,
// plus directed transactions with hand-computed latencies and data.
module tb_io_bus_ctrl;

  localparam int TO = 255;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  io_bus_ctrl_if #(.NUM_CH(3), .DATA_W(32)) bus ();

  io_bus_ctrl #(
    .NUM_CH (3),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Address map as the bench understands it: index = priority.
  localparam logic [31:0] BASES [3] = '{32'h10010000, 32'h10010010, 32'h00000030};
  localparam logic [31:0] MASKS [3] = '{32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFFC};

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 3; i++)
      if ((a & MASKS[i]) == (BASES[i] & MASKS[i])) return i;
    return -1;
  endfunction

  // ---------------- transaction-level model + per-cycle compare -------------
  int          cyc;
  bit          m_on, m_rst_prev, m_txn, m_bad, m_rerr, m_wr;
  int          m_c, m_tack, m_ch;
  logic [31:0] m_addr, m_wdata, m_rdata, m_err_addr;
  logic        e_req, e_active, e_ack;
  logic [2:0]  e_cs;

  always @(negedge clk) begin
    e_req = bus.cs && (bus.sig_r || bus.sig_w);
    if (m_on) begin
      if (m_rst_prev) begin
        chk("rst_ack", bus.ack, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_dev_cs", bus.dev_cs, 0);
        chk("rst_dev_we", bus.dev_we, 0);
        chk("rst_dev_wdata", bus.dev_wdata, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_err_addr", bus.err_addr, 0);
        chk("rst_stall", bus.stall, e_req);
      end else begin
        e_active = m_txn && !m_bad && (m_tack < 0 || cyc < m_tack);
        e_ack    = m_txn && (cyc == m_tack);
        e_cs     = e_active ? (3'b001 << m_ch) : 3'b000;
        chk("m_ack", bus.ack, e_ack);
        chk("m_err", bus.err, e_ack && m_rerr);
        chk("m_dev_cs", bus.dev_cs, e_cs);
        chk("m_stall", bus.stall, (!m_txn && e_req) || e_active);
        chk("m_err_addr", bus.err_addr, m_err_addr);
        if (e_active) begin
          chk("m_dev_we", bus.dev_we, m_wr);
          chk("m_dev_wdata", bus.dev_wdata, m_wdata);
        end
        if (e_ack) chk("m_rdata", bus.rdata, m_rdata);
      end
    end
    // advance the model with this cycle's inputs
    if (rst) begin
      m_on = 1; m_rst_prev = 1; m_txn = 0;
      m_rdata = '0; m_err_addr = '0;
    end else begin
      m_rst_prev = 0;
      if (m_txn && cyc == m_tack) begin
        m_txn = 0;
      end else if (m_txn && m_tack < 0) begin
        if (bus.dev_ready[m_ch]) begin
          m_tack = cyc + 1; m_rerr = 0;
          if (!m_wr) m_rdata = bus.dev_rdata[32*m_ch +: 32];
        end else if (cyc - m_c == TO) begin
          m_tack = cyc + 1; m_rerr = 1; m_rdata = '0; m_err_addr = m_addr;
        end
      end else if (!m_txn && e_req) begin
        m_txn = 1; m_c = cyc; m_addr = bus.addr; m_wr = bus.sig_w; m_wdata = bus.wdata;
        m_ch = decode(bus.addr);
        if ((bus.sig_r && bus.sig_w) || m_ch < 0) begin
          m_bad = 1; m_tack = cyc + 1; m_rerr = 1; m_rdata = '0; m_err_addr = bus.addr;
        end else begin
          m_bad = 0; m_tack = -1;
        end
      end
    end
    cyc++;
  end

  // ---------------- directed transactions ----------------------------------
  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [2:0]  cs_or;
    logic [2:0]  c1_cs;
    logic        c1_we;
    logic [31:0] c1_wdata;
    logic        stall_ok;
  } res_t;

  // Called just after a rising edge; cycle 0 is the request cycle.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                         input logic rd, input int ready_at, input logic [2:0] rmask,
                         output res_t r);
    r = '{lat: -1, err: 1'bx, rdata: 'x, cs_or: '0, c1_cs: 'x, c1_we: 1'bx,
          c1_wdata: 'x, stall_ok: 1'b1};
    bus.addr = a; bus.wdata = wd; bus.sig_w = wr; bus.sig_r = rd; bus.cs = 1'b1;
    bus.dev_ready = (ready_at <= 0) ? rmask : 3'b000;
    for (int i = 0; i <= TO + 8; i++) begin
      @(negedge clk);
      r.cs_or |= bus.dev_cs;
      if (i == 1) begin
        r.c1_cs = bus.dev_cs; r.c1_we = bus.dev_we; r.c1_wdata = bus.dev_wdata;
      end
      if (bus.ack) begin
        r.stall_ok &= (bus.stall == 1'b0);
        r.lat = i; r.err = bus.err; r.rdata = bus.rdata;
        break;
      end
      r.stall_ok &= (bus.stall == 1'b1);
      @(posedge clk); #1;
      bus.dev_ready = (i + 1 >= ready_at) ? rmask : 3'b000;
    end
    if (r.lat < 0) chk("ack_wait_expired", 32'(r.lat), 32'(TO + 1));
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.sig_r = 1'b0; bus.sig_w = 1'b0; bus.dev_ready = '0;
  endtask

  res_t r;
  logic acc;

  initial begin
    checks = 0; failures = 0; cyc = 0;
    m_on = 0; m_rst_prev = 0; m_txn = 0; m_err_addr = '0; m_rdata = '0;
    rst = 1'b1;
    bus.addr = '0; bus.wdata = '0; bus.cs = 1'b0; bus.sig_w = 1'b0; bus.sig_r = 1'b0;
    bus.dev_ready = '0;
    bus.dev_rdata = {32'h5A5A0033, 32'h000000A5, 32'hDEAD0000};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ack", bus.ack, 0);
    chk("reset_dev_cs", bus.dev_cs, 0);
    chk("reset_stall", bus.stall, 0);
    chk("reset_rdata", bus.rdata, 0);
    @(posedge clk); #1;

    run_txn(32'h10010000, 32'h1234ABCD, 1, 0, 0, 3'b001, r);
    chk("wr_lat", r.lat, 2);
    chk("wr_err", r.err, 0);
    chk("wr_c1_cs", r.c1_cs, 3'b001);
    chk("wr_c1_we", r.c1_we, 1);
    chk("wr_c1_wdata", r.c1_wdata, 32'h1234ABCD);
    chk("wr_stall", r.stall_ok, 1);

    run_txn(32'h10010014, 32'h0, 0, 1, 5, 3'b010, r);
    chk("rd_lat", r.lat, 6);
    chk("rd_err", r.err, 0);
    chk("rd_rdata", r.rdata, 32'h000000A5);
    chk("rd_cs_or", r.cs_or, 3'b010);
    chk("rd_stall", r.stall_ok, 1);

    run_txn(32'h00000030, 32'h0, 1, 1, 0, 3'b100, r);
    chk("dbl_lat", r.lat, 1);
    chk("dbl_err", r.err, 1);
    chk("dbl_cs_or", r.cs_or, 3'b000);
    chk("dbl_err_addr", bus.err_addr, 32'h00000030);

    run_txn(32'h20000000, 32'h0, 0, 1, 0, 3'b111, r);
    chk("unm_lat", r.lat, 1);
    chk("unm_err", r.err, 1);
    chk("unm_rdata", r.rdata, 0);
    chk("unm_cs_or", r.cs_or, 3'b000);
    chk("unm_err_addr", bus.err_addr, 32'h20000000);

    run_txn(32'h00000030, 32'h0, 0, 1, 100000, 3'b100, r);
    chk("to_lat", r.lat, 256);
    chk("to_err", r.err, 1);
    chk("to_rdata", r.rdata, 0);
    chk("to_cs_or", r.cs_or, 3'b100);
    chk("to_err_addr", bus.err_addr, 32'h00000030);

    run_txn(32'h00000031, 32'h0, 0, 1, 255, 3'b100, r);
    chk("late_rdy_lat", r.lat, 256);
    chk("late_rdy_err", r.err, 0);
    chk("late_rdy_rdata", r.rdata, 32'h5A5A0033);

    // back-to-back: second request presented in the cycle after the first ack
    run_txn(32'h1001000C, 32'h0, 0, 1, 1, 3'b001, r);
    chk("b2b1_lat", r.lat, 2);
    chk("b2b1_rdata", r.rdata, 32'hDEAD0000);
    run_txn(32'h1001001C, 32'hCAFEF00D, 1, 0, 1, 3'b010, r);
    chk("b2b2_lat", r.lat, 2);
    chk("b2b2_rdata_kept", r.rdata, 32'hDEAD0000);
    chk("b2b2_c1_wdata", r.c1_wdata, 32'hCAFEF00D);

    // reset in cycle 3 of a read that never gets ready
    bus.addr = 32'h10010014; bus.sig_r = 1'b1; bus.cs = 1'b1; bus.dev_ready = '0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_cs_before", bus.dev_cs, 3'b010);
    @(posedge clk); #1;
    rst = 1'b0; bus.cs = 1'b0; bus.sig_r = 1'b0;
    @(negedge clk);
    chk("mid_cs_after", bus.dev_cs, 0);
    chk("mid_rdata_after", bus.rdata, 0);
    chk("mid_err_addr_after", bus.err_addr, 0);
    chk("mid_dev_wdata_after", bus.dev_wdata, 0);
    acc = bus.ack;
    repeat (4) begin @(negedge clk); acc |= bus.ack; end
    chk("mid_no_ack", acc, 0);
    @(posedge clk); #1;
    run_txn(32'h10010000, 32'h0BADBEEF, 1, 0, 1, 3'b001, r);
    chk("post_rst_lat", r.lat, 2);
    chk("post_rst_err", r.err, 0);
    chk("post_rst_c1_cs", r.c1_cs, 3'b001);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=%0d required=%0d", $time, 100000);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
